// File: rtl/irf_ctl_pkg.sv
// Shared widths, FSM state type and array address packing for the
// windowed integer register file swap controller.
package irf_ctl_pkg;

  localparam int NTHR       = 4;
  localparam int NWIN       = 8;
  localparam int THR_W      = 2;
  localparam int WIN_W      = 3;
  localparam int IRF_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SAVE = 2'd1,
    ST_REST = 2'd2,
    ST_NULL = 2'd3
  } swap_state_e;

  // Window storage address seen by every register cell: {thread, cwp}.
  function automatic logic [IRF_ADDR_W-1:0] irf_addr(input logic [THR_W-1:0] thr,
                                                     input logic [WIN_W-1:0] cwp);
    return {thr, cwp};
  endfunction

endpackage

// File: rtl/irf_rr_arb4.sv
// 4-way round-robin arbiter; the search starts at the pointer, which moves
// one past the grantee whenever the grant is consumed.
module irf_rr_arb4
  import irf_ctl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_l,
  input  logic [3:0] req,
  input  logic       advance,
  output logic [3:0] gnt
);

  logic [1:0] ptr_reg;
  logic [3:0] req_rot;
  logic [1:0] off;
  logic [1:0] pick;
  logic       any;

  // Rotate so bit 0 is the thread the pointer names; lowest set bit wins.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      assign req_rot[gi] = req[ptr_reg + 2'(gi)];
      assign gnt[gi]     = any & (pick == 2'(gi));
    end
  endgenerate

  always_comb begin
    any = |req_rot;
    off = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req_rot[k]) off = 2'(k);
    end
    pick = ptr_reg + off;
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      ptr_reg <= 2'd0;
    end else if (advance && any) begin
      ptr_reg <= pick + 2'd1;
    end
  end

endmodule

// File: rtl/irf_window_swap_ctl.sv
// Register-window swap controller: arbitrates per-thread CWP swap requests and
// sequences save-then-restore on the shared register array ports.
module irf_window_swap_ctl #(
  parameter int NTHR = irf_ctl_pkg::NTHR,
  parameter int NWIN = irf_ctl_pkg::NWIN
) (
  input  logic                                 clk,
  input  logic                                 rst_l,
  input  logic [NTHR-1:0]                      swap_req,
  input  logic [NTHR*$clog2(NWIN)-1:0]         swap_old_cwp,
  input  logic [NTHR*$clog2(NWIN)-1:0]         swap_new_cwp,
  output logic [NTHR-1:0]                      swap_ack,
  output logic [NTHR-1:0]                      thr_stall,
  output logic                                 save,
  output logic [irf_ctl_pkg::IRF_ADDR_W-1:0]   save_addr,
  output logic                                 restore,
  output logic [irf_ctl_pkg::IRF_ADDR_W-1:0]   restore_addr,
  output logic                                 busy
);

  import irf_ctl_pkg::*;

  swap_state_e           state_reg, state_next;
  logic [THR_W-1:0]      thr_reg, thr_next;
  logic [WIN_W-1:0]      old_reg, old_next;
  logic [WIN_W-1:0]      new_reg, new_next;

  logic [3:0]            arb_req;
  logic [3:0]            gnt;
  logic                  advance;
  logic [THR_W-1:0]      gnt_idx;
  logic [WIN_W-1:0]      gnt_old, gnt_new;

  logic                  save_reg, save_next;
  logic                  restore_reg, restore_next;
  logic [IRF_ADDR_W-1:0] save_addr_reg, save_addr_next;
  logic [IRF_ADDR_W-1:0] restore_addr_reg, restore_addr_next;
  logic [NTHR-1:0]       ack_reg, ack_next;
  logic [NTHR-1:0]       last_ack_reg;
  logic                  ack_state;

  // The thread acked last cycle may still hold its stale request; hide it.
  assign arb_req = swap_req & ~last_ack_reg;

  irf_rr_arb4 u_arb (
    .clk     (clk),
    .rst_l   (rst_l),
    .req     (arb_req),
    .advance (advance),
    .gnt     (gnt)
  );

  always_comb begin
    gnt_idx = '0;
    gnt_old = '0;
    gnt_new = '0;
    for (int t = 0; t < NTHR; t++) begin
      if (gnt[t]) begin
        gnt_idx = THR_W'(t);
        gnt_old = swap_old_cwp[t*WIN_W +: WIN_W];
        gnt_new = swap_new_cwp[t*WIN_W +: WIN_W];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    thr_next   = thr_reg;
    old_next   = old_reg;
    new_next   = new_reg;
    advance    = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (|arb_req) begin
          advance    = 1'b1;
          thr_next   = gnt_idx;
          old_next   = gnt_old;
          new_next   = gnt_new;
          state_next = (gnt_old != gnt_new) ? ST_SAVE : ST_NULL;
        end
      end
      ST_SAVE: state_next = ST_REST;
      ST_REST: state_next = ST_IDLE;
      ST_NULL: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Strobes and addresses are registered from the next state so they are
  // stable for the whole cycle the array samples them in.
  always_comb begin
    save_next         = (state_next == ST_SAVE);
    restore_next      = (state_next == ST_REST);
    ack_state         = (state_next == ST_REST) || (state_next == ST_NULL);
    save_addr_next    = save_next    ? irf_addr(thr_next, old_next) : '0;
    restore_addr_next = restore_next ? irf_addr(thr_next, new_next) : '0;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NTHR; gi++) begin : g_thr
      assign ack_next[gi]  = ack_state & (thr_next == THR_W'(gi));
      assign thr_stall[gi] = rst_l & (swap_req[gi] | (busy & (thr_reg == THR_W'(gi))));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_reg        <= ST_IDLE;
      thr_reg          <= '0;
      old_reg          <= '0;
      new_reg          <= '0;
      save_reg         <= 1'b0;
      restore_reg      <= 1'b0;
      save_addr_reg    <= '0;
      restore_addr_reg <= '0;
      ack_reg          <= '0;
      last_ack_reg     <= '0;
    end else begin
      state_reg        <= state_next;
      thr_reg          <= thr_next;
      old_reg          <= old_next;
      new_reg          <= new_next;
      save_reg         <= save_next;
      restore_reg      <= restore_next;
      save_addr_reg    <= save_addr_next;
      restore_addr_reg <= restore_addr_next;
      ack_reg          <= ack_next;
      last_ack_reg     <= ack_reg;
    end
  end

  assign busy         = (state_reg != ST_IDLE);
  assign save         = save_reg;
  assign save_addr    = save_addr_reg;
  assign restore      = restore_reg;
  assign restore_addr = restore_addr_reg;
  assign swap_ack     = ack_reg;

endmodule

// File: tb/tb_irf_window_swap_ctl.sv
// Bench for irf_window_swap_ctl: a schedule-level reference model predicts each
// swap; a negedge monitor compares every cycle's outputs against it.
module tb_irf_window_swap_ctl;

  logic        clk = 1'b0;
  logic        rst_l;
  logic [3:0]  swap_req;
  logic [11:0] swap_old_cwp, swap_new_cwp;
  logic [3:0]  swap_ack, thr_stall;
  logic        save, restore, busy;
  logic [4:0]  save_addr, restore_addr;

  always #5 clk = ~clk;

  irf_window_swap_ctl dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .swap_req     (swap_req),
    .swap_old_cwp (swap_old_cwp),
    .swap_new_cwp (swap_new_cwp),
    .swap_ack     (swap_ack),
    .thr_stall    (thr_stall),
    .save         (save),
    .save_addr    (save_addr),
    .restore      (restore),
    .restore_addr (restore_addr),
    .busy         (busy)
  );

  typedef struct {
    int thr;
    int ow;
    int nw;
    bit nul;
    int g;
  } exp_t;

  exp_t exp_q[$];
  int   ack_thr_log[$];
  int   ack_cyc_log[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   drop_cyc[4];
  int   stale_mode = 1;

  function automatic int ack_of(input exp_t e);
    return e.g + (e.nul ? 1 : 2);
  endfunction

  // Reference model: one swap at a time, each occupying a fixed slot of cycles.
  initial begin
    int   ptr_m, mfree_m, lack_thr, lack_cyc, t;
    bit   found;
    exp_t e;
    ptr_m = 0; mfree_m = 0; lack_thr = -1; lack_cyc = -10;
    forever begin
      @(posedge clk);
      if (rst_l !== 1'b1) begin
        while (exp_q.size() > 0 && ack_of(exp_q[$]) > cyc) void'(exp_q.pop_back());
        ptr_m = 0; mfree_m = cyc + 1; lack_cyc = -10;
      end else if (cyc >= mfree_m) begin
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
          t = (ptr_m + k) % 4;
          if (!found && swap_req[t] && !(lack_cyc == cyc - 1 && lack_thr == t)) begin
            found = 1'b1;
            e.thr = t;
            e.ow  = int'(swap_old_cwp[3*t +: 3]);
            e.nw  = int'(swap_new_cwp[3*t +: 3]);
            e.nul = (e.ow == e.nw);
            e.g   = cyc;
            exp_q.push_back(e);
            ptr_m    = (t + 1) % 4;
            mfree_m  = cyc + (e.nul ? 2 : 3);
            lack_thr = t;
            lack_cyc = ack_of(e);
          end
        end
      end
      cyc++;
    end
  end

  // Monitor: compare the whole output bundle every cycle, pop on ack.
  initial begin
    exp_t       cur;
    int         a;
    bit         e_busy, e_save, e_rest, prev_save;
    logic [4:0] e_sa, e_ra, prev_sa;
    logic [3:0] e_ack, e_stall;
    logic [22:0] got_v, exp_v;
    prev_save = 1'b0; prev_sa = '0;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        e_busy = 0; e_save = 0; e_rest = 0; e_sa = '0; e_ra = '0; e_ack = '0;
        cur = '{thr: 0, ow: 0, nw: 0, nul: 0, g: 0};
        if (exp_q.size() > 0) begin
          cur = exp_q[0];
          a = ack_of(cur);
          if (cyc > cur.g && cyc <= a) begin
            e_busy = 1;
            if (!cur.nul && cyc == cur.g + 1) begin
              e_save = 1; e_sa = 5'(cur.thr * 8 + cur.ow);
            end
            if (cyc == a) begin
              e_ack = 4'(1 << cur.thr);
              if (!cur.nul) begin
                e_rest = 1; e_ra = 5'(cur.thr * 8 + cur.nw);
              end
            end
          end
        end
        e_stall = (rst_l === 1'b1) ? (swap_req | (e_busy ? 4'(1 << cur.thr) : 4'd0)) : 4'd0;
        got_v = {busy, save, save_addr, restore, restore_addr, swap_ack, thr_stall};
        exp_v = {e_busy, e_save, e_sa, e_rest, e_ra, e_ack, e_stall};
        vectors++;
        if (got_v !== exp_v) begin
          miscompares++;
          $display("FAIL outputs cyc=%0d got busy=%b save=%b sa=%0d rest=%b ra=%0d ack=%b stall=%b exp busy=%b save=%b sa=%0d rest=%b ra=%0d ack=%b stall=%b",
                   cyc, busy, save, save_addr, restore, restore_addr, swap_ack, thr_stall,
                   e_busy, e_save, e_sa, e_rest, e_ra, e_ack, e_stall);
        end else begin
          $display("cyc=%0d ok save=%b sa=%0d rest=%b ra=%0d ack=%b stall=%b", cyc, save, save_addr, restore, restore_addr, swap_ack, thr_stall);
        end
        if (e_ack != 0) void'(exp_q.pop_front());
        for (int t = 0; t < 4; t++) begin
          if (swap_ack[t] === 1'b1) begin
            ack_thr_log.push_back(t);
            ack_cyc_log.push_back(cyc);
          end
        end
        if (restore === 1'b1 && prev_save) begin
          vectors++;
          if (restore_addr === prev_sa) begin
            miscompares++;
            $display("FAIL hazard cyc=%0d restore_addr=%0d equals previous save_addr=%0d", cyc, restore_addr, prev_sa);
          end
        end
        prev_save = (save === 1'b1);
        prev_sa   = save_addr;
      end
    end
  end

  task automatic check(input string name, input int got, input int expv);
    vectors++;
    if (got != expv) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d", name, got, expv);
    end else begin
      $display("check %s ok value=%0d", name, got);
    end
  endtask

  // Advance one cycle and run the requester handshake for every thread.
  task automatic step();
    @(posedge clk);
    #1;
    for (int t = 0; t < 4; t++) begin
      if (swap_req[t] && drop_cyc[t] == cyc) swap_req[t] = 1'b0;
      if (swap_ack[t] === 1'b1)
        drop_cyc[t] = cyc + 1 + ((stale_mode == 1 || (stale_mode == 2 && $urandom_range(0, 1) == 1)) ? 1 : 0);
    end
  endtask

  function automatic bit can_raise(input int t);
    return !swap_req[t] && cyc > drop_cyc[t];
  endfunction

  task automatic raise(input int t, input int o, input int n);
    swap_old_cwp[3*t +: 3] = 3'(o);
    swap_new_cwp[3*t +: 3] = 3'(n);
    swap_req[t] = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (exp_q.size() == 0 && swap_req == 4'd0) return;
      step();
    end
    vectors++;
    miscompares++;
    $display("FAIL %s timeout after %0d cycles pending=%0d req=%b", name, bound, exp_q.size(), swap_req);
  endtask

  initial begin
    int base, c0, o, n;
    bit seen;
    rst_l = 1'b0;
    swap_req = 4'hF;
    for (int t = 0; t < 4; t++) begin
      swap_old_cwp[3*t +: 3] = 3'(t);
      swap_new_cwp[3*t +: 3] = 3'(t + 4);
      drop_cyc[t] = -1;
    end

    // Reset held two cycles with every thread requesting.
    step();
    check("reset_busy", int'(busy), 0);
    check("reset_outs", int'({save, restore, swap_ack, thr_stall, save_addr, restore_addr}), 0);
    step();
    rst_l = 1'b1;
    base = ack_thr_log.size();
    c0 = cyc;
    wait_idle("fairness", 60);
    check("fair_count", ack_thr_log.size() - base, 4);
    for (int k = 0; k < 4 && base + k < ack_thr_log.size(); k++) begin
      check($sformatf("fair_thr%0d", k), ack_thr_log[base+k], k);
      check($sformatf("fair_cyc%0d", k), ack_cyc_log[base+k] - c0, 2 + 3*k);
    end

    // Single swap thread 2, 3 -> 4.
    step();
    raise(2, 3, 4);
    c0 = cyc; base = ack_thr_log.size();
    wait_idle("single", 20);
    check("single_count", ack_thr_log.size() - base, 1);
    if (ack_thr_log.size() > base) begin
      check("single_thr", ack_thr_log[base], 2);
      check("single_lat", ack_cyc_log[base] - c0, 2);
    end

    // Null swap thread 1, 5 -> 5.
    step();
    raise(1, 5, 5);
    c0 = cyc; base = ack_thr_log.size();
    wait_idle("null", 20);
    check("null_count", ack_thr_log.size() - base, 1);
    if (ack_thr_log.size() > base) begin
      check("null_thr", ack_thr_log[base], 1);
      check("null_lat", ack_cyc_log[base] - c0, 1);
    end

    // Reset asserted during the SAVE cycle.
    step();
    raise(2, 1, 6);
    base = ack_thr_log.size();
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (save === 1'b1) seen = 1'b1;
    end
    check("midrst_save_seen", int'(seen), 1);
    rst_l = 1'b0;
    step();
    rst_l = 1'b1;
    wait_idle("midrst", 20);
    check("midrst_count", ack_thr_log.size() - base, 1);
    if (ack_thr_log.size() > base) check("midrst_thr", ack_thr_log[base], 2);

    // Threads 0 and 3 re-request as soon as allowed: grants must alternate.
    step();
    base = ack_thr_log.size();
    for (int i = 0; i < 40; i++) begin
      if (can_raise(0)) raise(0, $urandom_range(0, 7), $urandom_range(0, 7));
      if (can_raise(3)) raise(3, $urandom_range(0, 7), $urandom_range(0, 7));
      step();
    end
    wait_idle("starve", 30);
    check("starve_enough", int'(ack_thr_log.size() - base >= 6), 1);
    for (int k = base + 1; k < ack_thr_log.size(); k++) begin
      check($sformatf("starve_alt%0d", k - base), int'(ack_thr_log[k] != ack_thr_log[k-1]), 1);
      check($sformatf("starve_set%0d", k - base), int'(ack_thr_log[k] == 0 || ack_thr_log[k] == 3), 1);
    end

    // Random traffic with occasional resets and stale-request handshakes.
    stale_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      if (rst_l == 1'b0) rst_l = 1'b1;
      else if ($urandom_range(0, 149) == 0) rst_l = 1'b0;
      for (int t = 0; t < 4; t++) begin
        if (can_raise(t) && $urandom_range(0, 3) == 0) begin
          o = $urandom_range(0, 7);
          n = ($urandom_range(0, 3) == 0) ? o : $urandom_range(0, 7);
          raise(t, o, n);
        end else if (!swap_req[t]) begin
          swap_old_cwp[3*t +: 3] = 3'($urandom_range(0, 7));
          swap_new_cwp[3*t +: 3] = 3'($urandom_range(0, 7));
        end
      end
      step();
    end
    rst_l = 1'b1;
    wait_idle("random_drain", 200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
